action_capture: RTL and testbench
=================================

Name: action_capture

Overview:
- Input stage that sits directly upstream of the two-player game logic block.
- Per player, it synchronizes the six raw button levels (punch, kick, wait, jump, left, right) and detects rising edges.
- It holds at most one pending action per player and issues it as a single-clock one-hot pulse on each game tick, in the form the game logic consumes.
- It also applies an attack cooldown so a player cannot issue back-to-back punch/kick actions.

Parameters:
- TICK_DIV, 4: game tick period in clk cycles (≥2).
- COOLDOWN_TICKS, 1: ticks after an issued punch/kick during which new punch/kick presses are ignored. 0 disables the cooldown.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  game enable; freezes tick counter and capture when low.
- btn_punch1, btn_kick1, btn_wait1, btn_jump1, btn_left1, btn_right1  in  1 each  raw player-1 buttons, asynchronous levels.
- btn_punch2, btn_kick2, btn_wait2, btn_jump2, btn_left2, btn_right2  in  1 each  raw player-2 buttons.
- punch1, kick1, wait1, jump1, left1, right1  out  1 each  player-1 action pulses to game logic; at most one high.
- punch2, kick2, wait2, jump2, left2, right2  out  1 each  player-2 action pulses.
- tick  out  1  registered; high for one clk on each game tick.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port reset). All state updates on rising clk.
- Reset values: all action outputs 0, tick 0, tick counter 0, pending empty, cooldown counters 0, synchronizer and edge-history flops 0.
- Reset asserted mid-operation discards any pending action or cooldown on the next edge.
- Synchronizer:
  - 2-flop chain per raw input, followed by one history flop.
  - Edge = sync & ~history.
  - A raw level first sampled high at edge k produces an edge at k+2 and is captured into pending at edge k+2.
  - A held button yields exactly one edge; the button must go low and high again for a new edge.
- Pending capture, per player, while en=1:
  - Pending empty and one or more edges present: capture the highest-priority edge. Priority: punch > kick > jump > left > right > wait.
  - Pending occupied: new edges are ignored (first-come).
  - Cooldown > 0: punch/kick edges are ignored entirely and do not block lower-priority edges in the same cycle; the highest non-attack edge is captured.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 while en=1 and wraps.
  - tick is registered high on the edge where the counter wraps to 0, i.e. every TICK_DIV cycles.
  - en=0 holds the counter, forces tick and all actions to 0, and suppresses capture; synchronizers keep running.
- Issue:
  - On the edge that registers tick=1, each player's outputs take the one-hot of its pending action, and pending clears. Outputs are 0 on all other cycles.
  - Empty pending at tick: all outputs for that player stay 0; no implicit wait.
  - An edge in the same cycle as the issue is captured into the freshly cleared pending and goes out on the next tick; it is never lost.
- Cooldown, per player:
  - Loaded with COOLDOWN_TICKS when punch or kick is issued.
  - Decremented on each subsequent tick, saturating at 0.
  - Movement, jump and wait are never blocked.
- The two players are fully independent; simultaneous presses by both players are both issued on the same tick.
- Invariant: per player, at most one action output is high in any cycle, and only in the cycle tick is high.

Test Plan (TICK_DIV=4, COOLDOWN_TICKS=1):
- Reset released, no buttons pressed for 12 cycles → tick high on cycles 4, 8, 12; all action outputs stay 0.
- btn_right1 and btn_left2 pulsed high for 1 cycle before a tick → right1=1 and left2=1 together for exactly one cycle, coincident with the next tick; 0 afterwards.
- btn_punch1, btn_jump1 and btn_left1 rise in the same cycle → only punch1 is issued. A later btn_kick1 press before the next tick is ignored.
- punch1 issued, then btn_kick1 pressed within the following tick window → no kick1 on the next tick. A btn_kick1 re-press after that tick → kick1 issued on the subsequent tick.
- btn_wait2 held high for 20 cycles → wait2 is pulsed once only.
- Press captured, then en=0 for 10 cycles → no tick and no outputs. en back to 1 → tick and the pending action appear once the counter completes.
- reset asserted while an action is pending → next tick issues nothing.

Source files
------------

// File: rtl/action_capture.sv
// Two-player input stage: synchronizes raw buttons, detects rising edges, holds one
// pending action per player and issues it as a one-hot pulse on each game tick.
module action_capture #(
  parameter int TICK_DIV       = 4,
  parameter int COOLDOWN_TICKS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn_punch1,
  input  logic btn_kick1,
  input  logic btn_wait1,
  input  logic btn_jump1,
  input  logic btn_left1,
  input  logic btn_right1,
  input  logic btn_punch2,
  input  logic btn_kick2,
  input  logic btn_wait2,
  input  logic btn_jump2,
  input  logic btn_left2,
  input  logic btn_right2,
  output logic punch1,
  output logic kick1,
  output logic wait1,
  output logic jump1,
  output logic left1,
  output logic right1,
  output logic punch2,
  output logic kick2,
  output logic wait2,
  output logic jump2,
  output logic left2,
  output logic right2,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int CD_W  = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);

  // Action bit order: 0 punch, 1 kick, 2 wait, 3 jump, 4 left, 5 right.
  localparam logic [5:0] ATTACK_MASK = 6'b000011;

  function automatic logic [5:0] pick_action(input logic [5:0] e);
    logic [5:0] r;
    r = 6'b000000;
    if      (e[0]) r = 6'b000001;
    else if (e[1]) r = 6'b000010;
    else if (e[3]) r = 6'b001000;
    else if (e[4]) r = 6'b010000;
    else if (e[5]) r = 6'b100000;
    else if (e[2]) r = 6'b000100;
    return r;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             tick_now;
  logic [5:0]       raw     [2];
  logic [5:0]       act_all [2];

  assign raw[0] = {btn_right1, btn_left1, btn_jump1, btn_wait1, btn_kick1, btn_punch1};
  assign raw[1] = {btn_right2, btn_left2, btn_jump2, btn_wait2, btn_kick2, btn_punch2};

  assign tick_now = en && (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      tick <= tick_now;
      cnt  <= tick_now ? '0 : cnt + 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_player
    logic [5:0]      sync_p0, sync_p1, hist_p2;
    logic [5:0]      edges, cand, pend, act;
    logic [CD_W-1:0] cd;

    assign edges = sync_p1 & ~hist_p2;

    // Attack edges under cooldown are dropped before priority so they never mask movement.
    always_comb begin
      cand = pick_action((cd != '0) ? (edges & ~ATTACK_MASK) : edges);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync_p0 <= '0;
        sync_p1 <= '0;
        hist_p2 <= '0;
        pend    <= '0;
        act     <= '0;
        cd      <= '0;
      end else begin
        // stage p0 -> p1 -> p2: two-flop synchronizer then edge history
        sync_p0 <= raw[p];
        sync_p1 <= sync_p0;
        hist_p2 <= sync_p1;
        if (!en) begin
          act <= '0;
        end else if (tick_now) begin
          act  <= pend;
          pend <= cand;
          if ((pend & ATTACK_MASK) != '0) cd <= CD_W'(COOLDOWN_TICKS);
          else if (cd != '0)              cd <= cd - 1'b1;
        end else begin
          act <= '0;
          if (pend == '0) pend <= cand;
        end
      end
    end

    assign act_all[p] = act;
  end

  assign punch1 = act_all[0][0];
  assign kick1  = act_all[0][1];
  assign wait1  = act_all[0][2];
  assign jump1  = act_all[0][3];
  assign left1  = act_all[0][4];
  assign right1 = act_all[0][5];
  assign punch2 = act_all[1][0];
  assign kick2  = act_all[1][1];
  assign wait2  = act_all[1][2];
  assign jump2  = act_all[1][3];
  assign left2  = act_all[1][4];
  assign right2 = act_all[1][5];

endmodule

// File: tb/tb_action_capture.sv
// Scoreboard bench for action_capture: a tick/pending/cooldown reference model queues the
// expected outputs per clock; a monitor pops and compares them against the DUT.
module tb_action_capture;

  localparam int TICK_DIV       = 4;
  localparam int COOLDOWN_TICKS = 1;

  logic clk = 1'b0;
  logic reset, en;
  logic [5:0] btn [2];
  logic punch1, kick1, wait1, jump1, left1, right1;
  logic punch2, kick2, wait2, jump2, left2, right2;
  logic tick;

  action_capture #(.TICK_DIV(TICK_DIV), .COOLDOWN_TICKS(COOLDOWN_TICKS)) dut (
    .clk(clk), .reset(reset), .en(en),
    .btn_punch1(btn[0][0]), .btn_kick1(btn[0][1]), .btn_wait1(btn[0][2]),
    .btn_jump1(btn[0][3]), .btn_left1(btn[0][4]), .btn_right1(btn[0][5]),
    .btn_punch2(btn[1][0]), .btn_kick2(btn[1][1]), .btn_wait2(btn[1][2]),
    .btn_jump2(btn[1][3]), .btn_left2(btn[1][4]), .btn_right2(btn[1][5]),
    .punch1(punch1), .kick1(kick1), .wait1(wait1), .jump1(jump1), .left1(left1), .right1(right1),
    .punch2(punch2), .kick2(kick2), .wait2(wait2), .jump2(jump2), .left2(left2), .right2(right2),
    .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            tick;
    logic [1:0][5:0] a;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Reference model state: press history per player, enabled-cycle count, pending index
  // (-1 = empty) and remaining cooldown ticks.
  int         prio [6] = '{0, 1, 3, 4, 5, 2};
  logic [5:0] ago1 [2], ago2 [2], ago3 [2];
  int         pend [2];
  int         cd   [2];
  int         ecount;

  always @(posedge clk) begin
    exp_t       e;
    logic [5:0] ed;
    logic       tk;
    int         choice;
    cycle++;
    e = '0;
    if (reset) begin
      ecount = 0;
      for (int p = 0; p < 2; p++) begin
        pend[p] = -1; cd[p] = 0;
        ago1[p] = '0; ago2[p] = '0; ago3[p] = '0;
      end
    end else begin
      tk = 1'b0;
      if (en) begin
        ecount++;
        tk = ((ecount % TICK_DIV) == 0);
      end
      e.tick = tk;
      for (int p = 0; p < 2; p++) begin
        // a press seen two samples ago that was absent three samples ago
        ed = ago2[p] & ~ago3[p];
        if (en) begin
          choice = -1;
          for (int i = 0; i < 6; i++)
            if (choice < 0 && ed[prio[i]] && !(cd[p] > 0 && prio[i] < 2)) choice = prio[i];
          if (tk) begin
            if (pend[p] >= 0) e.a[p][pend[p]] = 1'b1;
            if (pend[p] == 0 || pend[p] == 1) cd[p] = COOLDOWN_TICKS;
            else if (cd[p] > 0)               cd[p] = cd[p] - 1;
            pend[p] = choice;
          end else if (pend[p] < 0) begin
            pend[p] = choice;
          end
        end
        ago3[p] = ago2[p];
        ago2[p] = ago1[p];
        ago1[p] = btn[p];
      end
    end
    expq.push_back(e);
  end

  initial begin : monitor
    exp_t e;
    exp_t obs;
    forever begin
      @(negedge clk);
      obs.tick = tick;
      obs.a[0] = {right1, left1, jump1, wait1, kick1, punch1};
      obs.a[1] = {right2, left2, jump2, wait2, kick2, punch2};
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty cycle=%0d got=%b required=an expected entry", cycle, obs);
      end else begin
        e = expq.pop_front();
        if (obs !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d got tick=%b p1=%b p2=%b required tick=%b p1=%b p2=%b",
                   cycle, obs.tick, obs.a[0], obs.a[1], e.tick, e.a[0], e.a[1]);
        end
      end
      checks++;
      if ($countones(obs.a[0]) > 1 || $countones(obs.a[1]) > 1 ||
          (!obs.tick && (obs.a[0] != 0 || obs.a[1] != 0))) begin
        failures++;
        $display("FAIL onehot_with_tick cycle=%0d got tick=%b p1=%b p2=%b required <=1 hot only with tick",
                 cycle, obs.tick, obs.a[0], obs.a[1]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int p, input logic [5:0] v, input int len);
    btn[p] = v;
    step(len);
    btn[p] = '0;
  endtask

  initial begin : stimulus
    int en_off;
    int rate;
    reset = 1'b1; en = 1'b1; btn[0] = '0; btn[1] = '0;
    step(2);
    reset = 1'b0;
    step(12);
    // right1 and left2 together
    btn[0] = 6'b100000; btn[1] = 6'b010000; step(1); btn[0] = '0; btn[1] = '0;
    step(8);
    // punch+jump+left simultaneously, then a kick before the next tick
    pulse(0, 6'b011001, 2); step(1); pulse(0, 6'b000010, 1); step(12);
    // kick inside cooldown window, then a re-press after it
    pulse(0, 6'b000001, 1); step(6); pulse(0, 6'b000010, 1); step(6);
    pulse(0, 6'b000010, 1); step(10);
    // wait2 held
    pulse(1, 6'b000100, 20); step(6);
    // capture, then freeze with en low
    pulse(0, 6'b001000, 1); step(4); en = 1'b0; step(10); en = 1'b1; step(8);
    // reset with an action pending
    pulse(1, 6'b010000, 1); step(3); reset = 1'b1; step(1); reset = 1'b0; step(10);
    // randomized traffic: busy phase then sparse phase
    en_off = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rate = (c < 1500) ? 5 : 29;
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 6; b++)
          if ($urandom_range(rate) == 0) btn[p][b] = ~btn[p][b];
      if (en_off > 0) en_off--;
      else if ($urandom_range(99) == 0) en_off = $urandom_range(12, 3);
      en    = (en_off == 0);
      reset = ($urandom_range(399) == 0);
    end
    reset = 1'b0; en = 1'b1; btn[0] = '0; btn[1] = '0;
    step(12);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d entries required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
